// File: rtl/decoder_out_buf.sv
// decoder_out_buf: first-word fall-through byte FIFO that captures one decoded byte per rising edge of the traceback done flag.
module decoder_out_buf #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 i_decoder_data,
  input  logic                       i_decoder_done,
  input  logic                       i_flush,
  input  logic                       i_rd_ready,
  output logic [7:0]                 o_rd_data,
  output logic                       o_rd_valid,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic [15:0]                o_byte_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          done_q, ovf_q, ovf_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic          capture, pop, push;
  always_comb begin
    capture  = i_decoder_done & ~done_q;
    pop      = o_rd_valid & i_rd_ready;
    push     = capture & (~o_full | pop);
    wr_ptr_d = i_flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = i_flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = i_flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = i_flush ? 1'b0 : ovf_q | (capture & o_full & ~pop);
    bcnt_d   = i_flush ? '0 : bcnt_q + 16'(push && bcnt_q != 16'hFFFF);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= i_decoder_done;
      ovf_q    <= ovf_d;
      bcnt_q   <= bcnt_d;
    end
  end
  // storage needs no reset; when full with a pop, the write lands on the slot being read out this cycle
  always_ff @(posedge clk)
    if (push && !i_flush) mem_q[wr_ptr_q] <= i_decoder_data;
  assign o_rd_data  = mem_q[rd_ptr_q];
  assign o_rd_valid = count_q != '0;
  assign o_count    = count_q;
  assign o_full     = count_q == (AW+1)'(DEPTH);
  assign o_overflow = ovf_q;
  assign o_byte_cnt = bcnt_q;
endmodule

// File: tb/tb_decoder_out_buf.sv
// tb_decoder_out_buf: directed scenarios plus random traffic checked against a queue-based model.
module tb_decoder_out_buf;
  localparam int DEPTH = 8;
  logic       clk = 0, rst = 0, done = 0, flush = 0, ready = 0;
  logic [7:0] data = 0;
  logic [7:0] o_rd_data;
  logic       o_rd_valid, o_full, o_overflow;
  logic [3:0] o_count;
  logic [15:0] o_byte_cnt;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mq[$];
  bit m_ovf, m_prev;
  int m_bcnt;

  decoder_out_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_decoder_data(data), .i_decoder_done(done),
    .i_flush(flush), .i_rd_ready(ready), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_count(o_count), .o_full(o_full),
    .o_overflow(o_overflow), .o_byte_cnt(o_byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    check("count", 32'(o_count), 32'(mq.size()));
    check("valid", 32'(o_rd_valid), 32'(mq.size() != 0));
    check("full", 32'(o_full), 32'(mq.size() == DEPTH));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("byte_cnt", 32'(o_byte_cnt), 32'(m_bcnt));
    if (mq.size() != 0) check("rd_data", 32'(o_rd_data), 32'(mq[0]));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_prev = 0;
    m_bcnt = 0;
  endtask

  // Apply inputs for one clock, advance the model by the documented rules, then compare.
  task automatic cycle(input bit d, input logic [7:0] v, input bit f, input bit r);
    bit cap, pp;
    int n;
    done = d; data = v; flush = f; ready = r;
    cap = d && !m_prev;
    n = mq.size();
    pp = r && n > 0;
    if (f) begin
      mq.delete();
      m_ovf = 0;
      m_bcnt = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (cap) begin
        if (n < DEPTH || pp) begin
          mq.push_back(v);
          if (m_bcnt < 65535) m_bcnt++;
        end else m_ovf = 1;
      end
    end
    m_prev = d;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 0;
    #2;
    model_reset();
    check_all();
    check("rst_count", 32'(o_count), 0);
    check("rst_valid", 32'(o_rd_valid), 0);
    rst = 1;
    #1;
  endtask

  task automatic push_byte(input logic [7:0] v);
    cycle(1, v, 0, 0);
    cycle(0, 8'h00, 0, 0);
  endtask

  initial begin
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1;
    // long done pulse gives a single capture
    for (int i = 0; i < 3; i++) cycle(1, 8'hA5, 0, 0);
    cycle(0, 8'h00, 0, 0);
    check("pulse_count", 32'(o_count), 1);
    check("pulse_data", 32'(o_rd_data), 32'hA5);
    cycle(0, 8'h00, 1, 0);
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("fill_full", 32'(o_full), 1);
    push_byte(8'h09);
    check("drop_ovf", 32'(o_overflow), 1);
    check("drop_count", 32'(o_count), 8);
    check("drop_bcnt", 32'(o_byte_cnt), 8);
    check("head_before", 32'(o_rd_data), 32'h01);
    cycle(1, 8'h55, 0, 1);
    check("fullpop_count", 32'(o_count), 8);
    check("fullpop_head", 32'(o_rd_data), 32'h02);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 0, 1);
    check("drained", 32'(o_count), 0);
    cycle(0, 8'h00, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'(8'h30 + i), 0, 1);
      cycle(0, 8'h00, 0, 1);
    end
    check("stream_bcnt", 32'(o_byte_cnt), 20);
    check("stream_count", 32'(o_count), 0);
    for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
    cycle(1, 8'hEE, 1, 1);
    check("flush_count", 32'(o_count), 0);
    check("flush_valid", 32'(o_rd_valid), 0);
    check("flush_bcnt", 32'(o_byte_cnt), 0);
    cycle(1, 8'hEF, 0, 0);
    check("no_recapture", 32'(o_count), 0);
    cycle(0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) push_byte(8'(8'h70 + i));
    do_reset();
    done = 1;
    do_reset();
    cycle(1, 8'h3C, 0, 0);
    check("release_capture", 32'(o_count), 1);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < (i % 200 < 100 ? 2 : 7));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decoder_out_buf.md
DECODER_OUT_BUF -- requirements
Module: decoder_out_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, the number of byte entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_decoder_data, input, 8 bits, the decoded byte from the traceback stage.
REQ-005 The block SHALL have port i_decoder_done, input, 1 bit, the byte-complete flag from traceback, which may stay high for several cycles.
REQ-006 The block SHALL have port i_flush, input, 1 bit, a synchronous clear of the buffer.
REQ-007 The block SHALL have port i_rd_ready, input, 1 bit, the consumer ready signal.
REQ-008 The block SHALL have port o_rd_data, output, 8 bits, the head byte.
REQ-009 The block SHALL have port o_rd_valid, output, 1 bit, asserted when the head byte is valid.
REQ-010 The block SHALL have port o_count, output, log2(DEPTH)+1 bits, the number of stored bytes.
REQ-011 The block SHALL have port o_full, output, 1 bit, asserted when o_count equals DEPTH.
REQ-012 The block SHALL have port o_overflow, output, 1 bit, a sticky flag set when a byte is dropped.
REQ-013 The block SHALL have port o_byte_cnt, output, 16 bits, the total number of bytes accepted since the last reset or flush.

Function
REQ-014 The block SHALL register i_decoder_done into done_q every cycle; capture SHALL equal i_decoder_done AND NOT done_q, so exactly one capture occurs per high pulse regardless of pulse length.
REQ-015 On capture, the block SHALL sample i_decoder_data in the same cycle in which the capture condition is true.
REQ-016 Push SHALL equal capture AND (NOT o_full OR pop); a byte captured while full with a simultaneous pop SHALL be accepted.
REQ-017 Pop SHALL equal o_rd_valid AND i_rd_ready.
REQ-018 o_rd_valid SHALL equal (o_count != 0); o_rd_data SHALL be the memory entry at rd_ptr (first-word fall-through, no registered output stage).
REQ-019 Latency: a byte captured at rising edge N SHALL be visible on o_rd_data/o_rd_valid after edge N; there SHALL be no same-cycle bypass from input to output.
REQ-020 wr_ptr and rd_ptr SHALL advance by 1 on push and pop respectively, wrapping modulo DEPTH.
REQ-021 o_count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-022 A capture while full and without a pop SHALL drop the byte, leave all storage and the count unchanged, and set o_overflow.
REQ-023 o_overflow SHALL clear only on reset or flush.
REQ-024 o_byte_cnt SHALL increment on every push and saturate at 0xFFFF.
REQ-025 When i_flush=1, the next edge SHALL zero the pointers, o_count, o_overflow and o_byte_cnt, and flush SHALL override push, pop and overflow in the same cycle; done_q SHALL still update, so a done pulse spanning the flush is not re-captured.
REQ-026 Pop while empty SHALL have no effect, and o_count SHALL never underflow.
REQ-027 Memory contents SHALL NOT need a reset; o_rd_data is don't-care while o_rd_valid=0.

Reset
REQ-028 While rst=0, asynchronously: pointers=0, o_count=0, o_full=0, o_rd_valid=0, o_overflow=0, o_byte_cnt=0, done_q=0.
REQ-029 A reset asserted mid-operation SHALL discard all stored bytes; after release, the first rising edge of i_decoder_done SHALL be captured normally.
REQ-030 If i_decoder_done is already high at reset release, it SHALL be captured once on the first edge, because done_q=0.

Verification
REQ-031 Hold i_decoder_done high for 3 cycles with data 0xA5 and ready=0 -> exactly one entry, o_count=1, o_rd_data=0xA5 one edge later.
REQ-032 Push bytes 0x01..0x08 with ready=0 and DEPTH=8 -> o_full=1; then capture 0x09 -> dropped, o_overflow=1, o_count=8, o_byte_cnt=8.
REQ-033 With the buffer full, capture 0x55 and pop in the same cycle -> o_count stays 8, 0x01 is popped, 0x55 is stored at the tail, o_overflow unchanged.
REQ-034 Stream 20 bytes with ready=1 -> output order matches input order across pointer wrap, o_byte_cnt=20, o_count returns to 0.
REQ-035 Assert i_flush together with a capture and a pop while o_count=3 -> next cycle o_count=0, o_rd_valid=0, o_overflow=0, o_byte_cnt=0.
REQ-036 Assert rst low with o_count=5 -> all outputs reach their reset values immediately, without waiting for a clock edge.
